hyperram_req_sequencer: RTL
===========================

Name: hyperram_req_sequencer

Overview:
Command sequencer directly upstream of hyperram_controller. Accepts one transaction request at a time over a valid/ready handshake and stages burst write data in a show-ahead FIFO. Issues the one-cycle ctrl_cs strobe with one-hot rd/wr and mem/reg selects, and tracks ctrl_busy to completion. Registers read data back to the user and reports done and error status.

Parameters:
WFIFO_DEPTH, 16, write-data FIFO depth in 32-bit words; power of two, 2..256.
BUSY_TIMEOUT, 64, cycles allowed between ctrl_cs and ctrl_busy asserting before error.

Ports:
clk  in  1  controller clock (200 MHz domain, same clock as hyperram_controller)
rst  in  1  asynchronous active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid && req_ready
req_rd_or_wr  in  1  1 = read, 0 = write
req_mem_or_reg  in  1  1 = register space, 0 = memory space
req_addr  in  32  start address
req_num_words  in  8  burst length in words; 0 treated as 1
req_latency  in  3  latency code, passed through
wd_valid  in  1  write-data push valid
wd_ready  out  1  FIFO not full
wd_data  in  32  write data word
rd_data  out  32  registered read data
rd_valid  out  1  one-cycle pulse per read word, no backpressure
done  out  1  one-cycle pulse at transaction end
err_timeout  out  1  sticky; cleared only by rst
err_underflow  out  1  sticky; set by pop on empty FIFO
ctrl_cs  out  1  one-cycle start strobe
ctrl_rd_sel, ctrl_wr_sel  out  1 each  one-hot direction
ctrl_mem_sel, ctrl_reg_sel  out  1 each  one-hot space
ctrl_num_words  out  8  latched burst length
ctrl_latency  out  3  latched latency
ctrl_addr_in  out  32  latched address
ctrl_wr_data_in  out  32  FIFO head word (show-ahead); 0 when empty
ctrl_wr_data_next  in  1  controller pops one FIFO word
ctrl_rd_data_out  in  32  controller read word
ctrl_rd_data_valid  in  1  controller read word valid
ctrl_busy  in  1  controller transaction in progress

Behaviour:
- Reset: all outputs 0, except wd_ready = 1. FSM to IDLE, FIFO emptied, error flags cleared. Reset mid-transaction aborts immediately; no done pulse.
- FSM states IDLE, ISSUE, WAIT_BUSY, ACTIVE, DONE.
- IDLE: req_ready = 1 when the request is a read, or a write with fifo_count >= effective num_words. Otherwise req_ready = 0. On accept, latch the request fields and go to ISSUE.
- ISSUE (1 cycle): ctrl_cs = 1, selects valid. Go to WAIT_BUSY.
- WAIT_BUSY: on ctrl_busy = 1 go to ACTIVE. If no busy within BUSY_TIMEOUT cycles, set err_timeout and go to DONE.
- ACTIVE: on ctrl_busy = 0 go to DONE.
- DONE (1 cycle): done = 1, return to IDLE.
- Minimum request-to-request spacing is 4 cycles plus the busy duration.
- Selects: ctrl_rd_sel = rd_or_wr, ctrl_wr_sel = !rd_or_wr, ctrl_reg_sel = mem_or_reg, ctrl_mem_sel = !mem_or_reg. All ctrl_* fields are held stable from ISSUE through DONE.
- FIFO: push on wd_valid && wd_ready. Pop on ctrl_wr_data_next. Simultaneous push and pop when full is allowed (count unchanged). Pointers wrap modulo WFIFO_DEPTH. Pop when empty sets err_underflow and leaves pointers unchanged. Requests with num_words > WFIFO_DEPTH are never accepted; the user must not issue them.
- Read path: rd_data/rd_valid register ctrl_rd_data_out/ctrl_rd_data_valid with 1-cycle latency, in every state. rd_data holds its last value.
- ctrl_busy asserting while in IDLE: ignored.

Optional Feature:
HYPERRAM_SEQ_STATS_EN — when defined, adds outputs stat_rd_cnt[31:0] and stat_wr_cnt[31:0]. Each increments on done for its direction and wraps at 2^32; both are reset by rst. When not defined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package hyperram_pkg: FSM state enum, RD = 1 / WR = 0 and REG = 1 / MEM = 0 encodings, widths ADDR_W = 32, DATA_W = 32, NWORDS_W = 8, LAT_W = 3.
- Sub-module hyperram_wr_fifo: show-ahead synchronous FIFO with count output and underflow flag.

Test Plan:
- Single read: req rd=1 mem, addr 0x100, n=1. Expect ctrl_cs pulse 1 cycle after accept, rd_sel = 1, mem_sel = 1. Model busy for 10 cycles, returning 0xDEADBEEF. Expect rd_valid with that data 1 cycle later, then done.
- Write gating: req wr, n=4, with 2 words in FIFO → req_ready = 0. Push 2 more words → accept. Four ctrl_wr_data_next pops present the words in push order; FIFO ends empty.
- FIFO full: push 16 words → wd_ready = 0. Simultaneous push and pop while full → count stays 16, order preserved.
- Timeout: issue a request, hold ctrl_busy = 0 → err_timeout set after 64 cycles, done pulses, next request accepted.
- Underflow plus num_words = 0: req wr, n = 0 → ctrl_num_words = 1. An extra pop on empty → err_underflow = 1, ctrl_wr_data_in = 0.
- Async reset asserted in ACTIVE: all outputs drop to reset values without a clock edge, FIFO empties, no done pulse.

Source files
------------

// File: rtl/hyperram_pkg.sv
// Shared types and encodings for the HyperRAM request sequencer.
// Direction/space encodings match the controller's rd/wr and mem/reg select semantics.
package hyperram_pkg;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int NWORDS_W = 8;
    localparam int LAT_W    = 3;

    localparam logic RD  = 1'b1;
    localparam logic WR  = 1'b0;
    localparam logic REG = 1'b1;
    localparam logic MEM = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_ACTIVE,
        ST_DONE
    } seq_state_t;

    // A burst length of zero still moves one word.
    function automatic logic [NWORDS_W-1:0] eff_words(input logic [NWORDS_W-1:0] n);
        return (n == '0) ? NWORDS_W'(1) : n;
    endfunction

endpackage

// File: rtl/hyperram_wr_fifo.sv
// Show-ahead write-data FIFO: head word is visible combinationally, 0 when empty.
// Popping an empty FIFO raises a sticky underflow flag and leaves the pointers alone.
module hyperram_wr_fifo
    import hyperram_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     underflow
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W:0]    count_reg;
    logic              underflow_reg;
    logic              empty;
    logic              do_pop;
    logic              do_push;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still take a word.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            underflow_reg <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (pop && empty) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    assign head      = empty ? '0 : mem[rd_ptr_reg];
    assign count     = count_reg;
    assign underflow = underflow_reg;

endmodule

// File: rtl/hyperram_req_sequencer.sv
// Request sequencer in front of hyperram_controller: accepts one request, strobes ctrl_cs,
// tracks ctrl_busy to completion. Optional counters via HYPERRAM_SEQ_STATS_EN.
module hyperram_req_sequencer
    import hyperram_pkg::*;
#(
    parameter int WFIFO_DEPTH  = 16,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_rd_or_wr,
    input  logic                req_mem_or_reg,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [NWORDS_W-1:0] req_num_words,
    input  logic [LAT_W-1:0]    req_latency,
    input  logic                wd_valid,
    output logic                wd_ready,
    input  logic [DATA_W-1:0]   wd_data,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                done,
    output logic                err_timeout,
    output logic                err_underflow,
    output logic                ctrl_cs,
    output logic                ctrl_rd_sel,
    output logic                ctrl_wr_sel,
    output logic                ctrl_mem_sel,
    output logic                ctrl_reg_sel,
    output logic [NWORDS_W-1:0] ctrl_num_words,
    output logic [LAT_W-1:0]    ctrl_latency,
    output logic [ADDR_W-1:0]   ctrl_addr_in,
    output logic [DATA_W-1:0]   ctrl_wr_data_in,
    input  logic                ctrl_wr_data_next,
    input  logic [DATA_W-1:0]   ctrl_rd_data_out,
    input  logic                ctrl_rd_data_valid,
    input  logic                ctrl_busy
`ifdef HYPERRAM_SEQ_STATS_EN
    ,
    output logic [31:0]         stat_rd_cnt,
    output logic [31:0]         stat_wr_cnt
`endif
);

    localparam int CNT_W = $clog2(WFIFO_DEPTH) + 1;
    localparam int TO_W  = $clog2(BUSY_TIMEOUT + 1);

    seq_state_t          state_reg;
    logic                idle_reg;
    logic [TO_W-1:0]     wait_cnt_reg;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_full;
    logic [NWORDS_W-1:0] req_eff;

    assign req_eff  = eff_words(req_num_words);
    // idle_reg keeps req_ready low while in reset and for the first cycle after it.
    assign req_ready = idle_reg &&
                       ((req_rd_or_wr == RD) || (16'(fifo_count) >= 16'(req_eff)));
    assign wd_ready  = !fifo_full || ctrl_wr_data_next;

    hyperram_wr_fifo #(
        .DEPTH (WFIFO_DEPTH)
    ) u_wr_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wd_valid && wd_ready),
        .push_data (wd_data),
        .pop       (ctrl_wr_data_next),
        .head      (ctrl_wr_data_in),
        .count     (fifo_count),
        .full      (fifo_full),
        .underflow (err_underflow)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            idle_reg       <= 1'b0;
            wait_cnt_reg   <= '0;
            ctrl_cs        <= 1'b0;
            ctrl_rd_sel    <= 1'b0;
            ctrl_wr_sel    <= 1'b0;
            ctrl_mem_sel   <= 1'b0;
            ctrl_reg_sel   <= 1'b0;
            ctrl_num_words <= '0;
            ctrl_latency   <= '0;
            ctrl_addr_in   <= '0;
            done           <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            ctrl_cs <= 1'b0;
            done    <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    idle_reg <= 1'b1;
                    if (req_valid && req_ready) begin
                        state_reg      <= ST_ISSUE;
                        idle_reg       <= 1'b0;
                        ctrl_cs        <= 1'b1;
                        ctrl_rd_sel    <= (req_rd_or_wr == RD);
                        ctrl_wr_sel    <= (req_rd_or_wr == WR);
                        ctrl_reg_sel   <= (req_mem_or_reg == REG);
                        ctrl_mem_sel   <= (req_mem_or_reg == MEM);
                        ctrl_num_words <= req_eff;
                        ctrl_latency   <= req_latency;
                        ctrl_addr_in   <= req_addr;
                    end
                end
                ST_ISSUE: begin
                    state_reg    <= ST_WAIT_BUSY;
                    wait_cnt_reg <= '0;
                end
                ST_WAIT_BUSY: begin
                    if (ctrl_busy) begin
                        state_reg <= ST_ACTIVE;
                    end else if (wait_cnt_reg == TO_W'(BUSY_TIMEOUT - 1)) begin
                        state_reg   <= ST_DONE;
                        done        <= 1'b1;
                        err_timeout <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (!ctrl_busy) begin
                        state_reg <= ST_DONE;
                        done      <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    idle_reg  <= 1'b1;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= ctrl_rd_data_valid;
            if (ctrl_rd_data_valid) begin
                rd_data <= ctrl_rd_data_out;
            end
        end
    end

`ifdef HYPERRAM_SEQ_STATS_EN
    // Counted on the done pulse; selects are still held at that point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_rd_cnt <= '0;
            stat_wr_cnt <= '0;
        end else if (done) begin
            if (ctrl_rd_sel) begin
                stat_rd_cnt <= stat_rd_cnt + 1'b1;
            end else begin
                stat_wr_cnt <= stat_wr_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
